// File: rtl/video_timing_gen_if.sv
// Config port bundle for video_timing_gen.
// Carries the valid/ready offer, timing fields and status flags.
interface video_timing_gen_if #(
   parameter int HW = 11,
   parameter int VW = 10
);
   logic          cfg_valid_in;
   logic          cfg_ready_out;
   logic [HW-1:0] cfg_h_active_in;
   logic [HW-1:0] cfg_h_fp_in;
   logic [HW-1:0] cfg_h_sync_in;
   logic [HW-1:0] cfg_h_bp_in;
   logic [VW-1:0] cfg_v_active_in;
   logic [VW-1:0] cfg_v_fp_in;
   logic [VW-1:0] cfg_v_sync_in;
   logic [VW-1:0] cfg_v_bp_in;
   logic          cfg_hs_pol_in;
   logic          cfg_vs_pol_in;
   logic          cfg_err_out;
   logic          cfg_pending_out;

   modport master (
      output cfg_valid_in,
      output cfg_h_active_in, cfg_h_fp_in,
      output cfg_h_sync_in, cfg_h_bp_in,
      output cfg_v_active_in, cfg_v_fp_in,
      output cfg_v_sync_in, cfg_v_bp_in,
      output cfg_hs_pol_in, cfg_vs_pol_in,
      input  cfg_ready_out,
      input  cfg_err_out,
      input  cfg_pending_out
   );

   modport slave (
      input  cfg_valid_in,
      input  cfg_h_active_in, cfg_h_fp_in,
      input  cfg_h_sync_in, cfg_h_bp_in,
      input  cfg_v_active_in, cfg_v_fp_in,
      input  cfg_v_sync_in, cfg_v_bp_in,
      input  cfg_hs_pol_in, cfg_vs_pol_in,
      output cfg_ready_out,
      output cfg_err_out,
      output cfg_pending_out
   );
endinterface

// File: rtl/video_timing_gen.sv
// Programmable video timing generator: counters, syncs, active draw,
// frame pulse/counter, line-compare pulse; new config applied at frame wrap.
module video_timing_gen #(
   parameter int HW           = 11,
   parameter int VW           = 10,
   parameter int FC_W         = 6,
   parameter int FC_MAX       = 59,
   parameter int DEF_H_ACTIVE = 1280,
   parameter int DEF_H_FP     = 110,
   parameter int DEF_H_SYNC   = 40,
   parameter int DEF_H_BP     = 220,
   parameter int DEF_V_ACTIVE = 720,
   parameter int DEF_V_FP     = 5,
   parameter int DEF_V_SYNC   = 5,
   parameter int DEF_V_BP     = 20,
   parameter bit DEF_HS_POL   = 1'b1,
   parameter bit DEF_VS_POL   = 1'b1
) (
   input  logic            clk_pixel_in,
   input  logic            rst_in,
   video_timing_gen_if.slave cfg,
   input  logic [VW-1:0]   line_cmp_in,
   output logic [HW-1:0]   hcount_out,
   output logic [VW-1:0]   vcount_out,
   output logic            hs_out,
   output logic            vs_out,
   output logic            ad_out,
   output logic            nf_out,
   output logic [FC_W-1:0] fc_out,
   output logic            line_irq_out
);

   typedef struct packed {
      logic [HW-1:0] h_active;
      logic [HW-1:0] h_fp;
      logic [HW-1:0] h_sync;
      logic [HW-1:0] h_bp;
      logic [VW-1:0] v_active;
      logic [VW-1:0] v_fp;
      logic [VW-1:0] v_sync;
      logic [VW-1:0] v_bp;
      logic          hs_pol;
      logic          vs_pol;
   } cfg_t;

   localparam cfg_t DEF_CFG = '{
      h_active: HW'(DEF_H_ACTIVE),
      h_fp:     HW'(DEF_H_FP),
      h_sync:   HW'(DEF_H_SYNC),
      h_bp:     HW'(DEF_H_BP),
      v_active: VW'(DEF_V_ACTIVE),
      v_fp:     VW'(DEF_V_FP),
      v_sync:   VW'(DEF_V_SYNC),
      v_bp:     VW'(DEF_V_BP),
      hs_pol:   DEF_HS_POL,
      vs_pol:   DEF_VS_POL
   };

   localparam logic [HW+1:0] H_LIM = (HW+2)'(1) << HW;
   localparam logic [VW+1:0] V_LIM = (VW+2)'(1) << VW;

   logic            last_rst;
   logic            hold;
   cfg_t            act;
   cfg_t            shd;
   cfg_t            in_cfg;
   logic            pending;
   logic            err_q;
   logic [HW-1:0]   hcount;
   logic [VW-1:0]   vcount;
   logic [FC_W-1:0] fc;

   logic [HW:0]     ht;
   logic [VW:0]     vt;
   logic [HW:0]     hs_start;
   logic [HW:0]     hs_end;
   logic [VW:0]     vs_start;
   logic [VW:0]     vs_end;
   logic [HW+1:0]   in_ht;
   logic [VW+1:0]   in_vt;
   logic            cfg_ok;
   logic            xfer;
   logic            h_last;
   logic            v_last;
   logic            fc_tick;
   logic            hs_on;
   logic            vs_on;

   assign hold = rst_in || last_rst;

   assign in_cfg = '{
      h_active: cfg.cfg_h_active_in,
      h_fp:     cfg.cfg_h_fp_in,
      h_sync:   cfg.cfg_h_sync_in,
      h_bp:     cfg.cfg_h_bp_in,
      v_active: cfg.cfg_v_active_in,
      v_fp:     cfg.cfg_v_fp_in,
      v_sync:   cfg.cfg_v_sync_in,
      v_bp:     cfg.cfg_v_bp_in,
      hs_pol:   cfg.cfg_hs_pol_in,
      vs_pol:   cfg.cfg_vs_pol_in
   };

   // Incoming totals get two extra bits: four max-width fields can't wrap.
   assign in_ht = (HW+2)'(in_cfg.h_active) + (HW+2)'(in_cfg.h_fp)
                + (HW+2)'(in_cfg.h_sync)   + (HW+2)'(in_cfg.h_bp);
   assign in_vt = (VW+2)'(in_cfg.v_active) + (VW+2)'(in_cfg.v_fp)
                + (VW+2)'(in_cfg.v_sync)   + (VW+2)'(in_cfg.v_bp);

   assign cfg_ok = (|in_cfg.h_active) && (|in_cfg.h_sync)
                && (|in_cfg.v_active) && (|in_cfg.v_sync)
                && (in_ht <= H_LIM) && (in_vt <= V_LIM);

   assign ht = (HW+1)'(act.h_active) + (HW+1)'(act.h_fp)
             + (HW+1)'(act.h_sync)   + (HW+1)'(act.h_bp);
   assign vt = (VW+1)'(act.v_active) + (VW+1)'(act.v_fp)
             + (VW+1)'(act.v_sync)   + (VW+1)'(act.v_bp);

   assign hs_start = (HW+1)'(act.h_active) + (HW+1)'(act.h_fp);
   assign hs_end   = hs_start + (HW+1)'(act.h_sync);
   assign vs_start = (VW+1)'(act.v_active) + (VW+1)'(act.v_fp);
   assign vs_end   = vs_start + (VW+1)'(act.v_sync);

   assign h_last  = ((HW+1)'(hcount) == ht - (HW+1)'(1));
   assign v_last  = ((VW+1)'(vcount) == vt - (VW+1)'(1));
   assign fc_tick = (hcount == act.h_active - HW'(1))
                 && (vcount == act.v_active);

   assign cfg.cfg_ready_out = !pending && !hold;
   assign xfer = cfg.cfg_valid_in && cfg.cfg_ready_out;

   always_ff @(posedge clk_pixel_in) begin
      last_rst <= rst_in;
      if (hold) begin
         hcount  <= '0;
         vcount  <= '0;
         fc      <= '0;
         act     <= DEF_CFG;
         shd     <= DEF_CFG;
         pending <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= xfer && !cfg_ok;
         hcount <= h_last ? '0 : hcount + HW'(1);
         if (h_last)
            vcount <= v_last ? '0 : vcount + VW'(1);
         if (fc_tick)
            fc <= (fc == FC_W'(FC_MAX)) ? '0 : fc + FC_W'(1);
         // Ready is low while pending, so apply and accept never collide.
         if (h_last && v_last && pending) begin
            act     <= shd;
            pending <= 1'b0;
         end else if (xfer && cfg_ok) begin
            shd     <= in_cfg;
            pending <= 1'b1;
         end
      end
   end

   assign hs_on = ((HW+1)'(hcount) >= hs_start)
               && ((HW+1)'(hcount) < hs_end);
   assign vs_on = ((VW+1)'(vcount) >= vs_start)
               && ((VW+1)'(vcount) < vs_end);

   assign hcount_out = hold ? '0 : hcount;
   assign vcount_out = hold ? '0 : vcount;
   assign fc_out     = hold ? '0 : fc;

   assign hs_out = (hs_on && !hold) ? act.hs_pol : ~act.hs_pol;
   assign vs_out = (vs_on && !hold) ? act.vs_pol : ~act.vs_pol;

   assign ad_out = !hold && (hcount < act.h_active)
                && (vcount < act.v_active);
   assign nf_out = !hold && (hcount == act.h_active)
                && (vcount == act.v_active);
   assign line_irq_out = !hold && (hcount == '0)
                      && (vcount == line_cmp_in);

   assign cfg.cfg_err_out     = err_q && !hold;
   assign cfg.cfg_pending_out = pending && !hold;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen with small 14x7 default timing.
// Expected frame shapes are hand-computed per config.
module tb_video_timing_gen;
   localparam int HW = 11;
   localparam int VW = 10;
   localparam int FC_W = 6;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [VW-1:0]   lc = VW'(3);
   logic [HW-1:0]   hcount;
   logic [VW-1:0]   vcount;
   logic            hs, vs, ad, nf, irq;
   logic [FC_W-1:0] fc;

   int n_chk = 0;
   int n_pass = 0;

   video_timing_gen_if #(.HW(HW), .VW(VW)) cfg ();

   video_timing_gen #(
      .HW(HW), .VW(VW), .FC_W(FC_W), .FC_MAX(2),
      .DEF_H_ACTIVE(8), .DEF_H_FP(2), .DEF_H_SYNC(2), .DEF_H_BP(2),
      .DEF_V_ACTIVE(4), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(1),
      .DEF_HS_POL(1'b1), .DEF_VS_POL(1'b1)
   ) dut (
      .clk_pixel_in(clk),
      .rst_in(rst),
      .cfg(cfg.slave),
      .line_cmp_in(lc),
      .hcount_out(hcount),
      .vcount_out(vcount),
      .hs_out(hs),
      .vs_out(vs),
      .ad_out(ad),
      .nf_out(nf),
      .fc_out(fc),
      .line_irq_out(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got,
                      input longint exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int ha, hf, hsy, hb,
                        input int va, vf, vsy, vb,
                        input logic hp, vp);
      cfg.cfg_h_active_in = HW'(ha);
      cfg.cfg_h_fp_in     = HW'(hf);
      cfg.cfg_h_sync_in   = HW'(hsy);
      cfg.cfg_h_bp_in     = HW'(hb);
      cfg.cfg_v_active_in = VW'(va);
      cfg.cfg_v_fp_in     = VW'(vf);
      cfg.cfg_v_sync_in   = VW'(vsy);
      cfg.cfg_v_bp_in     = VW'(vb);
      cfg.cfg_hs_pol_in   = hp;
      cfg.cfg_vs_pol_in   = vp;
      cfg.cfg_valid_in    = 1'b1;
   endtask

   task automatic wait_for(input int h, v, input string tag);
      int n = 0;
      while (!(hcount == HW'(h) && vcount == VW'(v)) && n < 2000) begin
         tick();
         n++;
      end
      chk({tag, ".reach"}, longint'(n < 2000), 1);
   endtask

   // Walks one frame from (0,0); leaves the bench at (0,0) of the next.
   task automatic check_frame(input string tag,
                              input int ht, vt, ha, va,
                              input int hs0, hs1, vs0, vs1,
                              input logic hp, vp, input int fcx);
      logic [4:0] ex;
      for (int v = 0; v < vt; v++) begin
         for (int h = 0; h < ht; h++) begin
            chk({tag, ".hc"}, hcount, h);
            chk({tag, ".vc"}, vcount, v);
            ex[4] = (h >= hs0 && h < hs1) ? hp : ~hp;
            ex[3] = (v >= vs0 && v < vs1) ? vp : ~vp;
            ex[2] = (h < ha) && (v < va);
            ex[1] = (h == ha) && (v == va);
            ex[0] = (h == 0) && (v == int'(lc));
            chk({tag, ".flags"}, {hs, vs, ad, nf, irq}, ex);
            if (h == ha && v == va) chk({tag, ".fc"}, fc, fcx);
            tick();
         end
      end
   endtask

   task automatic check_hold(input string tag);
      chk({tag, ".hc"}, hcount, 0);
      chk({tag, ".vc"}, vcount, 0);
      chk({tag, ".fc"}, fc, 0);
      chk({tag, ".flags"}, {hs, vs, ad, nf, irq}, 0);
      chk({tag, ".ready"}, cfg.cfg_ready_out, 0);
      chk({tag, ".pend"}, cfg.cfg_pending_out, 0);
      chk({tag, ".err"}, cfg.cfg_err_out, 0);
   endtask

   initial begin
      cfg.cfg_valid_in = 1'b0;
      offer(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
      cfg.cfg_valid_in = 1'b0;

      tick();
      tick();
      check_hold("rst");
      rst = 1'b0;
      #1;
      check_hold("rst+1");
      tick();
      chk("rel.ready", cfg.cfg_ready_out, 1);

      for (int k = 0; k < 4; k++)
         check_frame("dflt", 14, 7, 8, 4, 10, 12, 5, 6, 1'b1, 1'b1,
                     (k + 1) % 3);

      repeat (20) tick();
      offer(4, 1, 1, 2, 3, 1, 1, 1, 1'b0, 1'b1);
      tick();
      cfg.cfg_valid_in = 1'b0;
      chk("mid.pend", cfg.cfg_pending_out, 1);
      chk("mid.ready", cfg.cfg_ready_out, 0);
      chk("mid.err", cfg.cfg_err_out, 0);
      wait_for(13, 6, "mid");
      chk("mid.wrap_pend", cfg.cfg_pending_out, 1);
      tick();
      chk("apply.pend", cfg.cfg_pending_out, 0);
      chk("apply.ready", cfg.cfg_ready_out, 1);
      check_frame("newB", 8, 6, 4, 3, 5, 6, 4, 5, 1'b0, 1'b1, 0);

      offer(8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
      tick();
      cfg.cfg_valid_in = 1'b0;
      chk("back.pend", cfg.cfg_pending_out, 1);
      wait_for(7, 5, "back");
      tick();
      chk("back.apply", cfg.cfg_pending_out, 0);

      wait_for(13, 6, "edge");
      offer(4, 1, 1, 2, 3, 1, 1, 1, 1'b0, 1'b1);
      chk("edge.ready", cfg.cfg_ready_out, 1);
      tick();
      cfg.cfg_valid_in = 1'b0;
      chk("edge.pend", cfg.cfg_pending_out, 1);
      check_frame("edgeA", 14, 7, 8, 4, 10, 12, 5, 6, 1'b1, 1'b1, 0);
      chk("edge.apply", cfg.cfg_pending_out, 0);
      check_frame("edgeB", 8, 6, 4, 3, 5, 6, 4, 5, 1'b0, 1'b1, 1);

      offer(0, 1, 1, 2, 3, 1, 1, 1, 1'b0, 1'b1);
      tick();
      cfg.cfg_valid_in = 1'b0;
      chk("bad0.err", cfg.cfg_err_out, 1);
      chk("bad0.pend", cfg.cfg_pending_out, 0);
      chk("bad0.ready", cfg.cfg_ready_out, 1);
      tick();
      chk("bad0.err_off", cfg.cfg_err_out, 0);
      offer(2047, 1, 1, 0, 3, 1, 1, 1, 1'b0, 1'b1);
      tick();
      cfg.cfg_valid_in = 1'b0;
      chk("badht.err", cfg.cfg_err_out, 1);
      chk("badht.pend", cfg.cfg_pending_out, 0);
      tick();
      chk("badht.err_off", cfg.cfg_err_out, 0);
      wait_for(7, 5, "bad");
      tick();
      check_frame("badB", 8, 6, 4, 3, 5, 6, 4, 5, 1'b0, 1'b1, 0);

      lc = VW'(9);
      check_frame("lc9", 8, 6, 4, 3, 5, 6, 4, 5, 1'b0, 1'b1, 1);
      lc = VW'(3);

      offer(4, 1, 1, 2, 3, 1, 1, 1, 1'b0, 1'b1);
      tick();
      cfg.cfg_valid_in = 1'b0;
      chk("prst.pend", cfg.cfg_pending_out, 1);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      check_hold("rst2");
      rst = 1'b0;
      #1;
      check_hold("rst2+1");
      tick();
      check_frame("post", 14, 7, 8, 4, 10, 12, 5, 6, 1'b1, 1'b1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
